// File: rtl/audio_mac_sched.sv
`default_nettype none
// ============================================================================
// Module      : audio_mac_sched
// Description : Frame scheduler time-sharing one biquad MAC across channels
//               and filter stages (stage-major, channel-minor job order).
//               Optional stats: define AUDIO_SCHED_STATS_EN for busy_peak.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_mac_sched #(
    parameter int STAGES   = 2,
    parameter int CHANNELS = 2,
    parameter int TAPS     = 5,
    parameter int MAC_LAT  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_ce,
    input  logic [STAGES-1:0] en,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              sel_ch,
    output logic [1:0]        sel_stage,
    output logic [2:0]        sel_tap,
    output logic              acc_valid,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic [15:0]       busy_peak
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_RUN   = 3'd2;
    localparam logic [2:0] c_S_DRAIN = 3'd3;
    localparam logic [2:0] c_S_WB    = 3'd4;

    localparam logic [2:0] c_TAP_LAST = 3'(TAPS - 1);
    localparam logic [2:0] c_LAT_LAST = 3'(MAC_LAT - 1);
    localparam logic       c_CH_LAST  = 1'(CHANNELS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [2:0]        r_cnt;
    logic              r_ch;
    logic [1:0]        r_stage;
    logic [STAGES-1:0] r_en_snap;
    logic              r_overrun;
    logic              r_done_empty;

    logic              w_en_any;
    logic [1:0]        w_first_stage;
    logic [1:0]        w_next_stage;
    logic              w_has_next;
    logic              w_final_wb;
    logic              w_accept;
    logic              w_start;
    logic              w_busy;

    assign w_en_any = |en;

    // Lowest enabled stage of the incoming enable vector starts the frame.
    always_comb begin
        w_first_stage = 2'd0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (en[i]) begin
                w_first_stage = 2'(i);
            end
        end
    end

    // Lowest snapshotted stage above the current one is the next stage to run.
    always_comb begin
        w_has_next   = 1'b0;
        w_next_stage = 2'd0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (r_en_snap[i] && (i > int'(r_stage))) begin
                w_has_next   = 1'b1;
                w_next_stage = 2'(i);
            end
        end
    end

    assign w_busy     = (r_state != c_S_IDLE);
    assign w_final_wb = (r_state == c_S_WB) && (r_ch == c_CH_LAST) && !w_has_next;
    assign w_accept   = sample_ce && ((r_state == c_S_IDLE) || w_final_wb);
    assign w_start    = w_accept && w_en_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                w_state_nxt = c_S_RUN;
            end
            c_S_RUN: begin
                if (r_cnt == c_TAP_LAST) begin
                    w_state_nxt = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                if (r_cnt == c_LAT_LAST) begin
                    w_state_nxt = c_S_WB;
                end
            end
            c_S_WB: begin
                if (!w_final_wb || w_start) begin
                    w_state_nxt = c_S_LOAD;
                end else begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        mac_clr   = (r_state == c_S_LOAD);
        mac_en    = (r_state == c_S_RUN);
        sel_tap   = (r_state == c_S_RUN) ? r_cnt : 3'd0;
        acc_valid = (r_state == c_S_WB);
        busy      = w_busy;
        done      = w_final_wb || r_done_empty;
        sel_ch    = r_ch;
        sel_stage = r_stage;
        overrun   = r_overrun;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= 3'd0;
            r_ch         <= 1'b0;
            r_stage      <= 2'd0;
            r_en_snap    <= '0;
            r_overrun    <= 1'b0;
            r_done_empty <= 1'b0;
        end else begin
            // An accepted frame with nothing enabled completes on the following cycle.
            r_done_empty <= w_accept && !w_en_any;

            case (r_state)
                c_S_RUN:   r_cnt <= (r_cnt == c_TAP_LAST) ? 3'd0 : r_cnt + 3'd1;
                c_S_DRAIN: r_cnt <= r_cnt + 3'd1;
                default:   r_cnt <= 3'd0;
            endcase

            if (w_start) begin
                r_en_snap <= en;
                r_ch      <= 1'b0;
                r_stage   <= w_first_stage;
            end else if ((r_state == c_S_WB) && !w_final_wb) begin
                if (r_ch != c_CH_LAST) begin
                    r_ch <= r_ch + 1'b1;
                end else begin
                    r_ch    <= 1'b0;
                    r_stage <= w_next_stage;
                end
            end

            if (sample_ce && w_busy && !w_final_wb) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef AUDIO_SCHED_STATS_EN
    logic [15:0] r_busy_cnt;
    logic [15:0] r_busy_peak;
    logic [15:0] w_busy_cnt_inc;
    logic [15:0] w_peak_base;

    assign w_busy_cnt_inc = (r_busy_cnt == 16'hFFFF) ? r_busy_cnt : r_busy_cnt + 16'd1;
    assign w_peak_base    = overrun_clr ? 16'd0 : r_busy_peak;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy_cnt  <= 16'd0;
            r_busy_peak <= 16'd0;
        end else begin
            if (w_busy) begin
                r_busy_cnt <= w_final_wb ? 16'd0 : w_busy_cnt_inc;
            end
            // The count including the done cycle is the frame's full busy length.
            if (w_final_wb && (w_busy_cnt_inc > w_peak_base)) begin
                r_busy_peak <= w_busy_cnt_inc;
            end else begin
                r_busy_peak <= w_peak_base;
            end
        end
    end

    assign busy_peak = r_busy_peak;
`else
    assign busy_peak = 16'd0;
`endif

endmodule
`default_nettype wire
